// File: rtl/buzzer_pkg.sv
// -----------------------------------------------------------------------------
// buzzer_pkg
// Shared types and constants for the buzzer sequencer and its prescaler.
//   state_e      : sequencer states (idle, answer on/off, time-over on/off)
//   DEF_*        : default timing parameters (1 ms tick at 50 MHz)
//   phase_cnt_w  : phase counter width, from the longest phase in CLK cycles
//   rep_cnt_w    : repetition counter width, from the larger beep count
// -----------------------------------------------------------------------------
package buzzer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ANS_ON  = 3'd1,
      ST_ANS_OFF = 3'd2,
      ST_TO_ON   = 3'd3,
      ST_TO_OFF  = 3'd4
   } state_e;

   localparam int DEF_TICK_DIV = 50000;
   localparam int DEF_ANS_ON   = 100;
   localparam int DEF_ANS_OFF  = 100;
   localparam int DEF_ANS_REPS = 2;
   localparam int DEF_TO_ON    = 500;
   localparam int DEF_TO_OFF   = 200;
   localparam int DEF_TO_REPS  = 3;

   // Width covering the longest phase expressed in CLK cycles, so the phase
   // counter can never wrap regardless of how the phase is measured.
   function automatic int phase_cnt_w(input int div, input int a_on, input int a_off,
                                      input int t_on, input int t_off);
      int m;
      m = a_on;
      if (a_off > m) m = a_off;
      if (t_on  > m) m = t_on;
      if (t_off > m) m = t_off;
      return $clog2(m * div + 1);
   endfunction

   function automatic int rep_cnt_w(input int a_reps, input int t_reps);
      int m;
      m = (a_reps > t_reps) ? a_reps : t_reps;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/buzzer_sequencer_if.sv
// -----------------------------------------------------------------------------
// buzzer_sequencer_if
// Control-side bus between the quiz controller and the buzzer sequencer.
//   Answer_Req / TimeOver_Req : single-cycle event pulses from the controller
//   Mute                      : level, silences both tone requests
//   Buzzer_Enable / _TimeOver : registered tone requests to the tone generator
//   Busy / Done               : sequence running / end-of-sequence pulse
// master = controller side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface buzzer_sequencer_if;

   logic Answer_Req;
   logic TimeOver_Req;
   logic Mute;
   logic Buzzer_Enable;
   logic Buzzer_TimeOver;
   logic Busy;
   logic Done;

   modport master (
      output Answer_Req, TimeOver_Req, Mute,
      input  Buzzer_Enable, Buzzer_TimeOver, Busy, Done
   );

   modport slave (
      input  Answer_Req, TimeOver_Req, Mute,
      output Buzzer_Enable, Buzzer_TimeOver, Busy, Done
   );

endinterface

// File: rtl/buzzer_sequencer_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Restartable divide-by-DIV counter emitting a one-cycle tick every DIV cycles.
//   clk, rst : clock, synchronous active-high reset
//   restart  : next cycle begins a fresh DIV-cycle period (count 0)
//   tick     : high in the last cycle of each DIV-cycle period
// -----------------------------------------------------------------------------
module tick_prescaler #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int W = $clog2(DIV);

   logic [W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == W'(DIV - 1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (restart || tick) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/buzzer_sequencer.sv
// -----------------------------------------------------------------------------
// buzzer_sequencer
// Turns answer-granted / time-over events into timed, repeated beep patterns.
// Time-over beats answer (preempts a running answer sequence); one answer
// request can be held pending behind a time-over sequence.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : buzzer_sequencer_if.slave (requests, mute, tone outputs,
//              Busy, Done)
// -----------------------------------------------------------------------------
module buzzer_sequencer
   import buzzer_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int ANS_ON   = DEF_ANS_ON,
   parameter int ANS_OFF  = DEF_ANS_OFF,
   parameter int ANS_REPS = DEF_ANS_REPS,
   parameter int TO_ON    = DEF_TO_ON,
   parameter int TO_OFF   = DEF_TO_OFF,
   parameter int TO_REPS  = DEF_TO_REPS
) (
   input  logic              CLK,
   input  logic              RST,
   buzzer_sequencer_if.slave bus
);

   localparam int CNT_W = phase_cnt_w(TICK_DIV, ANS_ON, ANS_OFF, TO_ON, TO_OFF);
   localparam int REP_W = rep_cnt_w(ANS_REPS, TO_REPS);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] tcnt_q, tcnt_d, last_tick;
   logic [REP_W-1:0] rep_q, rep_d, last_rep;
   logic             pend_q, pend_d;
   logic             done_q, done_d;
   logic             en_q, en_d;
   logic             tov_q, tov_d;
   logic             tick, restart, phase_end;

   tick_prescaler #(.DIV(TICK_DIV)) u_presc (
      .clk    (CLK),
      .rst    (RST),
      .restart(restart),
      .tick   (tick)
   );

   // Index of the tick that closes the current phase, and of the last on-phase.
   always_comb begin
      last_tick = '0;
      last_rep  = '0;
      case (state_q)
         ST_ANS_ON:  begin last_tick = CNT_W'(ANS_ON - 1);  last_rep = REP_W'(ANS_REPS - 1); end
         ST_ANS_OFF: begin last_tick = CNT_W'(ANS_OFF - 1); last_rep = REP_W'(ANS_REPS - 1); end
         ST_TO_ON:   begin last_tick = CNT_W'(TO_ON - 1);   last_rep = REP_W'(TO_REPS - 1);  end
         ST_TO_OFF:  begin last_tick = CNT_W'(TO_OFF - 1);  last_rep = REP_W'(TO_REPS - 1);  end
         default:    ;
      endcase
   end

   assign phase_end = tick && (tcnt_q == last_tick);

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      rep_d   = rep_q;
      done_d  = 1'b0;
      tcnt_d  = tick ? tcnt_q + 1'b1 : tcnt_q;

      case (state_q)
         ST_IDLE: begin
            rep_d = '0;
            if (bus.TimeOver_Req) begin
               state_d = ST_TO_ON;
               pend_d  = bus.Answer_Req;   // simultaneous answer waits its turn
            end else if (bus.Answer_Req) begin
               state_d = ST_ANS_ON;
            end
         end

         ST_ANS_ON, ST_ANS_OFF: begin
            if (bus.TimeOver_Req) begin
               // Interrupted answer is dropped silently: no Done for it.
               state_d = ST_TO_ON;
               rep_d   = '0;
            end else if (phase_end) begin
               if (state_q == ST_ANS_OFF) begin
                  state_d = ST_ANS_ON;
               end else if (rep_q == last_rep) begin
                  state_d = ST_IDLE;
                  rep_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_ANS_OFF;
                  rep_d   = rep_q + 1'b1;
               end
            end
         end

         ST_TO_ON, ST_TO_OFF: begin
            if (bus.Answer_Req) pend_d = 1'b1;
            if (phase_end) begin
               if (state_q == ST_TO_OFF) begin
                  state_d = ST_TO_ON;
               end else if (rep_q == last_rep) begin
                  // An answer arriving on this very cycle still chains.
                  state_d = (pend_q || bus.Answer_Req) ? ST_ANS_ON : ST_IDLE;
                  pend_d  = 1'b0;
                  rep_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_TO_OFF;
                  rep_d   = rep_q + 1'b1;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Every phase starts with a zero tick count.
      if (state_d != state_q) tcnt_d = '0;
   end

   // Hold the prescaler at zero while idle and realign it on every phase
   // change, so each phase (including preemption) starts at full length.
   assign restart = (state_q == ST_IDLE) || (state_d != state_q);

   assign en_d  = (state_d == ST_ANS_ON) && !bus.Mute;
   assign tov_d = (state_d == ST_TO_ON)  && !bus.Mute;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         tcnt_q  <= '0;
         rep_q   <= '0;
         pend_q  <= 1'b0;
         done_q  <= 1'b0;
         en_q    <= 1'b0;
         tov_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         rep_q   <= rep_d;
         pend_q  <= pend_d;
         done_q  <= done_d;
         en_q    <= en_d;
         tov_q   <= tov_d;
      end
   end

   assign bus.Buzzer_Enable   = en_q;
   assign bus.Buzzer_TimeOver = tov_q;
   assign bus.Busy            = (state_q != ST_IDLE);
   assign bus.Done            = done_q;

endmodule
